// File: rtl/coinc_pkg.sv
// Shared types, default widths and saturating arithmetic for the coincidence counter.
package coinc_pkg;

    localparam int CNT_W  = 32;
    localparam int WIN_W  = 8;
    localparam int GATE_W = 32;

    // Widest counter the saturating helper can serve.
    localparam int SAT_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                  input logic [SAT_W-1:0] max);
        return (v >= max) ? max : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/coinc_edge_window.sv
// Per-channel rising-edge detector plus coincidence window timer.
module coinc_edge_window
    import coinc_pkg::*;
#(
    parameter int WIN_W = coinc_pkg::WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic [WIN_W-1:0] win_len,
    input  logic             clr,
    output logic             ev,
    output logic             tmr_active
);

    logic             pulse_q;
    logic [WIN_W-1:0] tmr;

    assign ev         = pulse & ~pulse_q;
    assign tmr_active = (tmr != '0);

    // clr wins over a fresh event so a paired edge cannot open a new window.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
            tmr     <= '0;
        end else begin
            pulse_q <= pulse;
            if (clr)
                tmr <= '0;
            else if (ev)
                tmr <= win_len;
            else if (tmr != '0)
                tmr <= tmr - WIN_W'(1);
        end
    end

endmodule

// File: rtl/coincidence_counter.sv
// Gated A/B singles and coincidence counter with a valid/ready result port.
// Define COINC_AUTO_RESTART_EN to allow start on the result handshake to launch the next gate directly.
module coincidence_counter
    import coinc_pkg::*;
#(
    parameter int CNT_W  = coinc_pkg::CNT_W,
    parameter int WIN_W  = coinc_pkg::WIN_W,
    parameter int GATE_W = coinc_pkg::GATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_a,
    input  logic              pulse_b,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_ab,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    // Result handshake: res_valid is high for the whole DONE state and the
    // counts are stable while it is high; a result transfers on a clock edge
    // where res_valid && res_ready, after which res_valid drops.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [WIN_W-1:0]   win_q;
    logic [GATE_W-1:0]  gate_cnt;
    logic               ev_a, ev_b;
    logic               act_a, act_b;
    logic               coinc;
    logic               take_start;
    logic               tmr_clr;
    logic               sat_hit;

    assign state_dbg = state;

    assign coinc = (ev_a && (ev_b || act_b)) || (ev_b && (ev_a || act_a));

`ifdef COINC_AUTO_RESTART_EN
    assign take_start = start && ((state == IDLE) ||
                                  (state == DONE && res_valid && res_ready));
`else
    assign take_start = start && (state == IDLE);
`endif

    assign tmr_clr = take_start || ((state == RUN) && coinc);

    assign sat_hit = (ev_a  && (cnt_a  == CNT_MAX)) ||
                     (ev_b  && (cnt_b  == CNT_MAX)) ||
                     (coinc && (cnt_ab == CNT_MAX));

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_W'(v), SAT_W'(CNT_MAX)));
    endfunction

    coinc_edge_window #(.WIN_W(WIN_W)) u_win_a (
        .clk        (clk),
        .rst        (rst),
        .pulse      (pulse_a),
        .win_len    (win_q),
        .clr        (tmr_clr),
        .ev         (ev_a),
        .tmr_active (act_a)
    );

    coinc_edge_window #(.WIN_W(WIN_W)) u_win_b (
        .clk        (clk),
        .rst        (rst),
        .pulse      (pulse_b),
        .win_len    (win_q),
        .clr        (tmr_clr),
        .ev         (ev_b),
        .tmr_active (act_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            overflow  <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            cnt_ab    <= '0;
            win_q     <= '0;
            gate_cnt  <= '0;
        end else if (take_start) begin
            cnt_a    <= '0;
            cnt_b    <= '0;
            cnt_ab   <= '0;
            overflow <= 1'b0;
            win_q    <= win_len;
            gate_cnt <= gate_len;
            // A zero-length gate has nothing to count, so it reports at once.
            if (gate_len == '0) begin
                state     <= DONE;
                busy      <= 1'b0;
                res_valid <= 1'b1;
            end else begin
                state     <= RUN;
                busy      <= 1'b1;
                res_valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
                RUN: begin
                    if (ev_a)
                        cnt_a <= bump(cnt_a);
                    if (ev_b)
                        cnt_b <= bump(cnt_b);
                    if (coinc)
                        cnt_ab <= bump(cnt_ab);
                    if (sat_hit)
                        overflow <= 1'b1;
                    gate_cnt <= gate_cnt - GATE_W'(1);
                    if (gate_cnt == GATE_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed bench for coincidence_counter: a 32-bit and a 4-bit instance share stimulus; results are scoreboarded.
module tb_coincidence_counter;

    localparam int CW  = 32;
    localparam int SW  = 4;
    localparam int WW  = 8;
    localparam int GW  = 32;
    localparam int RW  = 3*CW + 1;
    localparam int RSW = 3*SW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_a = 1'b0;
    logic          pulse_b = 1'b0;
    logic          start = 1'b0;
    logic          res_ready = 1'b1;
    logic [WW-1:0] win_len = '0;
    logic [GW-1:0] gate_len = '0;

    logic          busy, res_valid, overflow;
    logic [CW-1:0] cnt_a, cnt_b, cnt_ab;
    logic [1:0]    state_dbg;
    logic          s_busy, s_res_valid, s_overflow;
    logic [SW-1:0] s_cnt_a, s_cnt_b, s_cnt_ab;
    logic [1:0]    s_state_dbg;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0]  exp_q[$];
    logic [RSW-1:0] exps_q[$];

    always #5 clk = ~clk;

    coincidence_counter #(.CNT_W(CW), .WIN_W(WW), .GATE_W(GW)) dut (
        .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b),
        .win_len(win_len), .gate_len(gate_len), .start(start),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_ab(cnt_ab),
        .overflow(overflow), .state_dbg(state_dbg)
    );

    coincidence_counter #(.CNT_W(SW), .WIN_W(WW), .GATE_W(GW)) dut_s (
        .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b),
        .win_len(win_len), .gate_len(gate_len), .start(start),
        .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
        .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .cnt_ab(s_cnt_ab),
        .overflow(s_overflow), .state_dbg(s_state_dbg)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] sat4(input int v);
        return (v > 15) ? 4'hF : SW'(v);
    endfunction

    task automatic push_exp(input int a, input int b, input int ab);
        logic so;
        so = (a > 15) || (b > 15) || (ab > 15);
        exp_q.push_back({CW'(a), CW'(b), CW'(ab), 1'b0});
        exps_q.push_back({sat4(a), sat4(b), sat4(ab), so});
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_gate(input int g, input int w);
        gate_len = GW'(g);
        win_len  = WW'(w);
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
    endtask

    task automatic edge_a(input int gap);
        pulse_a = 1'b1; cyc(1); pulse_a = 1'b0;
        if (gap > 0) cyc(gap);
    endtask

    task automatic edge_b(input int gap);
        pulse_b = 1'b1; cyc(1); pulse_b = 1'b0;
        if (gap > 0) cyc(gap);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", res_valid, 1);
        cyc(1);
        n = 0;
        while (res_valid && n < bound) begin
            cyc(1);
            n++;
        end
        chk("back_to_idle", state_dbg, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [RW-1:0]  e;
        logic [RSW-1:0] es;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                chk("result_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("cnt_a",    cnt_a,    e[RW-1 -: CW]);
                    chk("cnt_b",    cnt_b,    e[RW-1-CW -: CW]);
                    chk("cnt_ab",   cnt_ab,   e[CW:1]);
                    chk("overflow", overflow, e[0]);
                end
            end
            if (!rst && s_res_valid && res_ready) begin
                chk("small_result_pending", exps_q.size() != 0, 1);
                if (exps_q.size() != 0) begin
                    es = exps_q.pop_front();
                    chk("small_cnt_a",    s_cnt_a,    es[RSW-1 -: SW]);
                    chk("small_cnt_b",    s_cnt_b,    es[RSW-1-SW -: SW]);
                    chk("small_cnt_ab",   s_cnt_ab,   es[SW:1]);
                    chk("small_overflow", s_overflow, es[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic ok;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_ab", cnt_ab, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        cyc(2);

        // Three isolated A edges, no B.
        push_exp(3, 0, 0);
        start_gate(100, 4);
        chk("t1_busy", busy, 1);
        edge_a(19); edge_a(19); edge_a(19);
        wait_done(200);

        // B lands exactly on the last window cycle.
        push_exp(1, 1, 1);
        start_gate(20, 4);
        edge_a(3); edge_b(0);
        wait_done(100);

        // B one cycle past the window.
        push_exp(1, 1, 0);
        start_gate(20, 4);
        edge_a(4); edge_b(0);
        wait_done(100);

        // Same-cycle edges with a zero window.
        push_exp(1, 1, 1);
        start_gate(10, 0);
        pulse_a = 1'b1; pulse_b = 1'b1; cyc(1);
        pulse_a = 1'b0; pulse_b = 1'b0;
        wait_done(100);

        // Held pulse counts once.
        push_exp(1, 0, 0);
        start_gate(50, 4);
        pulse_a = 1'b1; cyc(30); pulse_a = 1'b0;
        wait_done(100);

        // A, B, B inside one window pairs only once.
        push_exp(1, 2, 1);
        start_gate(20, 4);
        edge_a(0); edge_b(1); edge_b(0);
        wait_done(100);

        // Exact gate length: 7 RUN cycles then DONE.
        push_exp(0, 0, 0);
        start_gate(7, 4);
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!busy || res_valid) ok = 1'b0;
            cyc(1);
        end
        @(negedge clk);
        chk("gate_len_run", ok, 1);
        chk("gate_len_done", res_valid, 1);
        cyc(1);
        chk("gate_len_idle", state_dbg, 0);

        // Dead time: DONE held with res_ready low while A toggles.
        push_exp(0, 0, 0);
        res_ready = 1'b0;
        start_gate(10, 4);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("dead_valid_seen", res_valid, 1);
        cyc(1);
        for (int i = 0; i < 50; i++) begin
            pulse_a = ~pulse_a;
            cyc(1);
        end
        pulse_a = 1'b0;
        @(negedge clk);
        chk("dead_cnt_a", cnt_a, 0);
        chk("dead_valid_held", res_valid, 1);
        chk("dead_state", state_dbg, 2);
        cyc(1);
        res_ready = 1'b1;
        wait_done(20);

        // Zero-length gate reports immediately.
        push_exp(0, 0, 0);
        start_gate(0, 4);
        @(negedge clk);
        chk("zero_gate_valid", res_valid, 1);
        chk("zero_gate_busy", busy, 0);
        cyc(1);
        chk("zero_gate_idle", state_dbg, 0);

        // 20 A edges: wide counter 20, 4-bit counter saturates at 15.
        push_exp(20, 0, 0);
        start_gate(100, 0);
        for (int i = 0; i < 20; i++) edge_a(1);
        wait_done(200);

        // Reset in the middle of a gate.
        start_gate(100, 4);
        edge_a(2);
        chk("mid_run_cnt_a", cnt_a, 1);
        chk("mid_run_busy", busy, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", res_valid, 0);
        chk("rst_mid_cnt_a", cnt_a, 0);
        chk("rst_mid_state", state_dbg, 0);
        chk("rst_mid_small_cnt_a", s_cnt_a, 0);
        cyc(1);

        // Normal operation resumes after reset.
        push_exp(0, 1, 0);
        start_gate(20, 4);
        edge_b(0);
        wait_done(100);

        cyc(3);
        chk("scoreboard_drained", exp_q.size() + exps_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
